dma_fifo_arbiter: RTL

DMA_FIFO_ARBITER -- requirements
Module: dma_fifo_arbiter

---
 rtl/dma_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/dma_fifo_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the DMA-to-FIFO arbitration block.
package dma_pkg;

    localparam int DMA_DATA_WIDTH = 96;
    localparam int DMA_NUM_REQ    = 3;
    localparam int DMA_MAX_BURST  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: scans from last_grant+1 upward and
// wraps, returning the first requesting channel.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               any_req
);

    logic [IDW-1:0]     cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the channel gi+1 positions after the previous grant.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDW'((int'(last_grant) + gi + 1) % NUM_REQ);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest hit wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/dma_fifo_arbiter.sv
// Grants one DMA channel at a time to a shared FIFO write port; a grant lasts
// until the channel's last beat or MAX_BURST accepted beats.
module dma_fifo_arbiter
    import dma_pkg::*;
#(
    parameter int  NUM_REQ    = DMA_NUM_REQ,
    parameter int  DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int  MAX_BURST  = DMA_MAX_BURST,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW        = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            cfg_chan_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [IDW-1:0]        rr_winner;
    logic                  rr_any;
    logic [DATA_WIDTH-1:0] chan_data [NUM_REQ];
    logic [BCW-1:0]        beat_cnt_inc;
    logic                  accept;
    logic                  burst_end;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
            assign chan_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign eligible = req_valid & cfg_chan_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req        (eligible),
        .last_grant (last_grant_q),
        .winner     (rr_winner),
        .any_req    (rr_any)
    );

    // cfg_chan_en is deliberately not consulted here: disabling a channel
    // mid-burst only affects the next arbitration.
    assign beat_cnt_inc = beat_cnt_q + BCW'(1);
    assign accept       = (state_q == LOCKED) && req_valid[grant_q] && !fifo_full && !rst;
    assign burst_end    = accept && (req_last[grant_q] || (beat_cnt_inc == BCW'(MAX_BURST)));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;

        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    state_d    = LOCKED;
                    grant_d    = rr_winner;
                    beat_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    req_ready[grant_q] = 1'b1;
                    fifo_wr_en         = 1'b1;
                    fifo_wr_data       = chan_data[grant_q];
                    beat_cnt_d         = beat_cnt_inc;
                end
                if (burst_end) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant starts at the top channel so the first search begins at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == LOCKED);

endmodule
